grid_clear_ctrl: RTL and testbench
==================================

Name: grid_clear_ctrl

Overview:
- Sequences the playfield grid RAM after a piece locks. Scans rows bottom-to-top, drops every completely filled row, compacts the remaining rows downward, and blanks the freed rows at the top.
- Shares the single grid RAM port with the render path through a request/grant handshake, and only drives the port while granted.
- Reports how many lines were cleared to the scoring logic.

Parameters:
- ROWS, 18, number of grid rows (row 0 = top, ROWS-1 = bottom)
- COLS, 10, cells per row
- CELL_W, 4, bits per cell: {occupied, color[2:0]}

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse from game logic after a piece locks
- mem_gnt  in  1  arbiter grant; an access is accepted in any cycle where mem_req && mem_gnt
- mem_rdata  in  COLS*CELL_W  row read data, valid exactly 1 cycle after an accepted read
- mem_req  out  1  port request
- mem_we  out  1  1 = write, 0 = read; meaningful only while mem_req=1
- mem_addr  out  5  row address
- mem_wdata  out  COLS*CELL_W  row write data
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at completion
- lines_cleared  out  5  full rows removed in the last run; held until the next start

Behaviour:
- Reset: all outputs are 0, state IDLE, src=dst=ROWS-1. Reset mid-run aborts on the next edge with no further accesses; the RAM may be left partially compacted and this is accepted.
- Row full: AND of the occupied bits of all COLS cells.
- States:
  - IDLE: on start, clear lines_cleared, set src=dst=ROWS-1, go to RD. start while busy is ignored.
  - RD: mem_req=1, mem_we=0, mem_addr=src; hold until granted, then go to EV.
  - EV: capture mem_rdata into the row register.
    - If the row is full: lines_cleared+1, go to NX.
    - Else if src!=dst: go to WR.
    - Else: dst-1, go to NX.
  - WR: mem_req=1, mem_we=1, mem_addr=dst, mem_wdata=row register; hold until granted, then dst-1, go to NX.
  - NX: if src==0, go to FL if lines_cleared>0, else DN. Otherwise src-1 and go to RD.
  - FL: write all-zero data at dst; on grant, if dst==0 go to DN, else dst-1.
  - DN: done=1 for 1 cycle, busy=0, go to IDLE.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable while ungranted.
  - The grant may drop for any number of cycles; there is no timeout.
  - mem_req=0 in IDLE, EV, NX and DN.
- Counters: src and dst never underflow. FL is entered only when dst = lines_cleared-1.
- Latency with continuous grant:
  - No clears: 18×3 cycles for RD/EV/NX, plus DN.
  - With clears: add one WR cycle per moved row and one FL cycle per cleared row.
- The row register captures mem_rdata only in EV, which always immediately follows a granted read.

Decomposition:
- grid_pkg:
  - GRID_ROWS, GRID_COLS, CELL_W and ROW_W constants
  - cell_t struct {occupied, color}
  - color enum (RED, GREEN, BLUE, WHITE, YELLOW, PURPLE, ORANGE, PINK)
  - state enum for this FSM
- Sub-module row_full_detect (combinational AND-reduce over the occupied bits). This is shared with the spawn/game-over check.

Test Plan:
- No full rows, continuous grant, random partial rows → 18 reads, 0 writes; done after 18×3+1 cycles; lines_cleared=0; RAM unchanged.
- Rows 17 and 15 full, continuous grant → row16 written to 17; rows 14..0 shifted down by 2; rows 1 and 0 written all-zero; lines_cleared=2; the RAM model matches the golden compaction.
- All 18 rows full → no WR writes; 18 FL writes of zero covering rows 17..0; lines_cleared=18.
- Row 10 full, mem_gnt toggling pseudo-randomly at 30% → final RAM identical to the continuous-grant result; mem_addr/mem_we/mem_wdata never change while mem_req=1 and mem_gnt=0.
- start pulsed again while busy; Reset asserted during WR → the second start is ignored; after reset busy=0, done=0, mem_req=0, lines_cleared=0 on the next cycle, with no access on the following cycles.
- Back-to-back runs: start asserted the cycle after done → a second run with lines_cleared restarting from 0 and correct compaction of the already-compacted grid (lines_cleared=0).

Source files
------------

// File: rtl/grid_pkg.sv
// Shared playfield grid definitions: geometry, cell layout, colour codes and
// the line-clear sequencer state encoding.
package grid_pkg;

  localparam int GRID_ROWS = 18;
  localparam int GRID_COLS = 10;
  localparam int CELL_W    = 4;
  localparam int ROW_W     = GRID_COLS * CELL_W;

  typedef enum logic [2:0] {
    RED    = 3'd0,
    GREEN  = 3'd1,
    BLUE   = 3'd2,
    WHITE  = 3'd3,
    YELLOW = 3'd4,
    PURPLE = 3'd5,
    ORANGE = 3'd6,
    PINK   = 3'd7
  } color_e;

  typedef struct packed {
    logic   occupied;
    color_e color;
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_EV   = 3'd2,
    ST_WR   = 3'd3,
    ST_NX   = 3'd4,
    ST_FL   = 3'd5,
    ST_DN   = 3'd6
  } state_e;

endpackage

// File: rtl/row_full_detect.sv
// Row-full detector: a row is full when every cell's occupied bit is set.
// Takes the already-extracted occupied bits so the spawn/game-over check can
// reuse it without carrying the colour bits around.
module row_full_detect #(
  parameter int COLS = grid_pkg::GRID_COLS
) (
  input  logic [COLS-1:0] occ_i,
  output logic            full_o
);

  // AND-reduce the occupied bits of all cells
  always_comb begin
    full_o = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      full_o = full_o & occ_i[c];
    end
  end

endmodule

// File: rtl/grid_clear_ctrl.sv
// Line-clear sequencer: after a piece locks it walks the grid bottom-to-top,
// drops full rows, compacts the survivors downward and blanks the freed rows
// at the top. The single RAM port is shared with the render path, so every
// access is held stable until the arbiter grants it. All outputs are flops
// computed from the next-state values.
module grid_clear_ctrl #(
  parameter int ROWS   = grid_pkg::GRID_ROWS,
  parameter int COLS   = grid_pkg::GRID_COLS,
  parameter int CELL_W = grid_pkg::CELL_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic                     mem_gnt,
  input  logic [COLS*CELL_W-1:0]   mem_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [4:0]               mem_addr,
  output logic [COLS*CELL_W-1:0]   mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic [4:0]               lines_cleared
);

  import grid_pkg::*;

  localparam int         DATA_W   = COLS * CELL_W;
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_e             state_q, state_d;
  logic [4:0]         src_q, src_d;
  logic [4:0]         dst_q, dst_d;
  logic [4:0]         lines_q, lines_d;
  logic [DATA_W-1:0]  row_q, row_d;

  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [4:0]         mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [COLS-1:0]    occ_s;
  logic               row_full_s;

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_q;

  // Pick the occupied bit (cell MSB) out of every cell of the read data
  always_comb begin
    occ_s = '0;
    for (int c = 0; c < COLS; c++) begin
      occ_s[c] = mem_rdata[c*CELL_W + CELL_W - 1];
    end
  end

  row_full_detect #(
    .COLS (COLS)
  ) u_row_full (
    .occ_i  (occ_s),
    .full_o (row_full_s)
  );

  // Sequencer next-state: row pointers, clear count and captured row
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    lines_d = lines_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          lines_d = 5'd0;
          src_d   = LAST_ROW;
          dst_d   = LAST_ROW;
          state_d = ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (mem_gnt) begin
          state_d = ST_EV;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_EV: begin
        // Read data is valid exactly here: the previous cycle was a granted read
        row_d = mem_rdata;
        if (row_full_s) begin
          lines_d = lines_q + 5'd1;
          state_d = ST_NX;
        end else if (src_q != dst_q) begin
          state_d = ST_WR;
        end else begin
          // Row already in place; guard keeps dst from wrapping below row 0
          if (dst_q != 5'd0) begin
            dst_d = dst_q - 5'd1;
          end else begin
            dst_d = dst_q;
          end
          state_d = ST_NX;
        end
      end
      ST_WR: begin
        if (mem_gnt) begin
          if (dst_q != 5'd0) begin
            dst_d = dst_q - 5'd1;
          end else begin
            dst_d = dst_q;
          end
          state_d = ST_NX;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_NX: begin
        if (src_q == 5'd0) begin
          if (lines_q != 5'd0) begin
            state_d = ST_FL;
          end else begin
            state_d = ST_DN;
          end
        end else begin
          src_d   = src_q - 5'd1;
          state_d = ST_RD;
        end
      end
      ST_FL: begin
        // dst counts down from lines_cleared-1 to row 0, blanking as it goes
        if (mem_gnt) begin
          if (dst_q == 5'd0) begin
            state_d = ST_DN;
          end else begin
            dst_d   = dst_q - 5'd1;
            state_d = ST_FL;
          end
        end else begin
          state_d = ST_FL;
        end
      end
      ST_DN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the port and status lines leave flops
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 5'd0;
    mem_wdata_d = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      ST_RD: begin
        mem_req_d  = 1'b1;
        mem_addr_d = src_d;
        busy_d     = 1'b1;
      end
      ST_WR: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = dst_d;
        mem_wdata_d = row_d;
        busy_d      = 1'b1;
      end
      ST_FL: begin
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        mem_addr_d = dst_d;
        busy_d     = 1'b1;
      end
      ST_EV, ST_NX: begin
        busy_d = 1'b1;
      end
      ST_DN: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, pointers and registered outputs with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      src_q       <= LAST_ROW;
      dst_q       <= LAST_ROW;
      lines_q     <= 5'd0;
      row_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 5'd0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      lines_q     <= lines_d;
      row_q       <= row_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_grid_clear_ctrl.sv
// Scoreboard bench for grid_clear_ctrl: a RAM model answers the port, a
// reference compaction model predicts every access and the final grid, and a
// monitor process checks each granted access and each completion.
module tb_grid_clear_ctrl;
  import grid_pkg::*;

  localparam int ROWS  = GRID_ROWS;
  localparam int COLS  = GRID_COLS;

  typedef struct packed {
    logic              we;
    logic [4:0]        addr;
    logic [ROW_W-1:0]  data;
  } acc_t;

  typedef struct {
    int lines;
    int cycles;
    bit chk_cycles;
  } done_t;

  logic              Clk, Reset, start, mem_gnt;
  logic [ROW_W-1:0]  mem_rdata;
  logic              mem_req, mem_we, busy, done;
  logic [4:0]        mem_addr, lines_cleared;
  logic [ROW_W-1:0]  mem_wdata;

  logic [ROW_W-1:0]  ram    [ROWS];
  logic [ROW_W-1:0]  img    [ROWS];
  logic [ROW_W-1:0]  golden [ROWS];
  logic              load_en;

  acc_t  exp_q[$];
  done_t exp_done_q[$];

  int  vectors, miscompares;
  bit  sb_en, gnt_rand;
  int  busy_cnt;

  grid_clear_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .start         (start),
    .mem_gnt       (mem_gnt),
    .mem_rdata     (mem_rdata),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit row_is_full(input logic [ROW_W-1:0] r);
    int n = 0;
    for (int c = 0; c < COLS; c++) begin
      if (r[c*CELL_W + CELL_W - 1]) n++;
    end
    return n == COLS;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row(input bit full);
    logic [ROW_W-1:0] r;
    int hole;
    for (int c = 0; c < COLS; c++) begin
      r[c*CELL_W + CELL_W - 1] = full ? 1'b1 : 1'($urandom_range(0, 1));
      r[c*CELL_W +: 3]         = 3'($urandom_range(0, 7));
    end
    if (!full) begin
      hole = $urandom_range(0, COLS - 1);
      r[hole*CELL_W + CELL_W - 1] = 1'b0;
    end
    return r;
  endfunction

  // RAM model: one registered read per granted read, writes land on grant
  always @(posedge Clk) begin
    if (load_en) begin
      for (int r = 0; r < ROWS; r++) ram[r] <= img[r];
    end else if (mem_req && mem_gnt && mem_we) begin
      if (mem_addr < 5'(ROWS)) ram[mem_addr] <= mem_wdata;
    end
    if (mem_req && mem_gnt && !mem_we && mem_addr < 5'(ROWS))
      mem_rdata <= ram[mem_addr];
    else
      mem_rdata <= {$urandom, $urandom};
  end

  // Grant driver: always granted, or granted about 30% of cycles
  initial begin
    mem_gnt = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      mem_gnt = gnt_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Reference model: survivors stack at the bottom in order, cleared count of
  // blank rows on top; one read per row bottom-up, a write only when a row moves
  task automatic build_model(input bit chk_cycles);
    int kept, cleared, moved, d;
    acc_t a;
    done_t e;
    kept = 0; cleared = 0; moved = 0;
    for (int s = ROWS - 1; s >= 0; s--) begin
      a.we = 1'b0; a.addr = 5'(s); a.data = '0;
      exp_q.push_back(a);
      if (row_is_full(ram[s])) begin
        cleared++;
      end else begin
        d = ROWS - 1 - kept;
        golden[d] = ram[s];
        if (d != s) begin
          a.we = 1'b1; a.addr = 5'(d); a.data = ram[s];
          exp_q.push_back(a);
          moved++;
        end
        kept++;
      end
    end
    for (int f = cleared - 1; f >= 0; f--) begin
      golden[f] = '0;
      a.we = 1'b1; a.addr = 5'(f); a.data = '0;
      exp_q.push_back(a);
    end
    e.lines = cleared;
    e.cycles = 3 * ROWS + moved + cleared;
    e.chk_cycles = chk_cycles;
    exp_done_q.push_back(e);
  endtask

  // Monitor: checks granted accesses, held requests and completion results
  initial begin
    acc_t  a;
    done_t e;
    logic  prev_req, prev_gnt;
    logic [46:0] prev_bus;
    prev_req = 1'b0; prev_gnt = 1'b0; prev_bus = '0;
    forever begin
      @(negedge Clk);
      if (!sb_en || Reset) begin
        busy_cnt = 0;
        prev_req = 1'b0;
      end else begin
        if (prev_req && !prev_gnt)
          chk("hold_stable", {17'd0, mem_req, mem_we, mem_addr, mem_wdata}, {17'd0, prev_bus});
        if (busy) busy_cnt++;
        if (mem_req && mem_gnt) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL acc_extra: got access addr %0d we %0b expected none", mem_addr, mem_we);
          end else begin
            a = exp_q.pop_front();
            chk("acc_we", 64'(mem_we), 64'(a.we));
            chk("acc_addr", 64'(mem_addr), 64'(a.addr));
            if (a.we) chk("acc_data", 64'(mem_wdata), 64'(a.data));
          end
        end
        if (done) begin
          if (exp_done_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL done_extra: got done expected none");
          end else begin
            e = exp_done_q.pop_front();
            chk("lines_cleared", 64'(lines_cleared), 64'(e.lines));
            chk("acc_missing", 64'(exp_q.size()), 64'd0);
            chk("busy_at_done", 64'(busy), 64'd0);
            if (e.chk_cycles) chk("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
          end
          busy_cnt = 0;
        end
        prev_req = mem_req;
        prev_gnt = mem_gnt;
        prev_bus = {mem_req, mem_we, mem_addr, mem_wdata};
      end
    end
  end

  task automatic load_img();
    load_en = 1'b1;
    @(posedge Clk);
    #1 load_en = 1'b0;
  endtask

  // Start a run (optionally pulsing start again mid-run) and wait for done
  task automatic run(input bit do_load, input bit rnd, input bit twice);
    bit seen;
    gnt_rand = rnd;
    if (do_load) load_img();
    @(posedge Clk);
    #1;
    build_model(!rnd);
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    if (twice) begin
      repeat (4) @(posedge Clk);
      #1 start = 1'b1;
      @(posedge Clk);
      #1 start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge Clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (!seen) begin
      exp_q.delete();
      exp_done_q.delete();
    end
    for (int r = 0; r < ROWS; r++) chk($sformatf("ram_row%0d", r), 64'(ram[r]), 64'(golden[r]));
  endtask

  initial begin
    bit seen;
    Clk = 1'b0; Reset = 1'b1; start = 1'b0; load_en = 1'b0;
    sb_en = 1'b0; gnt_rand = 1'b0; busy_cnt = 0;
    vectors = 0; miscompares = 0;
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_lines", 64'(lines_cleared), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    sb_en = 1'b1;

    // No full rows: reads only, grid unchanged
    for (int r = 0; r < ROWS; r++) img[r] = rand_row(1'b0);
    run(1'b1, 1'b0, 1'b0);

    // Rows 17 and 15 full
    for (int r = 0; r < ROWS; r++) img[r] = rand_row(r == 17 || r == 15);
    run(1'b1, 1'b0, 1'b0);

    // Every row full: only blanking writes
    for (int r = 0; r < ROWS; r++) img[r] = rand_row(1'b1);
    run(1'b1, 1'b0, 1'b0);

    // Row 10 full with a stuttering grant and a start pulse while busy
    for (int r = 0; r < ROWS; r++) img[r] = rand_row(r == 10);
    run(1'b1, 1'b1, 1'b1);

    // Back-to-back rerun on the compacted grid
    run(1'b0, 1'b0, 1'b0);

    // Reset while a row write is pending
    for (int r = 0; r < ROWS; r++) img[r] = rand_row(r == 17);
    gnt_rand = 1'b0;
    load_img();
    @(posedge Clk);
    #1;
    build_model(1'b1);
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    @(posedge Clk);
    #1 start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge Clk);
      if (mem_req && mem_we) seen = 1'b1;
    end
    chk("wr_seen", 64'(seen), 64'd1);
    #1 sb_en = 1'b0;
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_req", 64'(mem_req), 64'd0);
    chk("abort_lines", 64'(lines_cleared), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("abort_idle_req", 64'(mem_req), 64'd0);
    end
    exp_q.delete();
    exp_done_q.delete();
    sb_en = 1'b1;

    // Random grids with random grant, chained back-to-back
    for (int r = 0; r < ROWS; r++) img[r] = rand_row($urandom_range(0, 3) == 0);
    run(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      run(1'b0, 1'b1, 1'b0);
    end
    for (int r = 0; r < ROWS; r++) img[r] = rand_row($urandom_range(0, 1) == 0);
    run(1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
